// File: rtl/spi_arb_pkg.sv
// Shared definitions for the SPI master arbiter: FSM encoding and the
// round-robin pointer advance.
package spi_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_ISSUE     = 2'd1,
    ST_WAIT_BUSY = 2'd2,
    ST_WAIT_DONE = 2'd3
  } arb_state_t;

  function automatic int unsigned rr_next(input int unsigned idx, input int unsigned n);
    return (idx + 32'd1 >= n) ? 32'd0 : idx + 32'd1;
  endfunction

endpackage

// File: rtl/spi_master_arbiter_rr_select.sv
// Combinational round-robin pick: first set request at or above the pointer,
// wrapping modulo NUM_REQ. Returns one-hot, index and a found flag.
module rr_select #(
  parameter int NUM_REQ = 2,
  parameter int PW      = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic [NUM_REQ-1:0] i_req,
  input  logic [PW-1:0]      i_ptr,
  output logic [NUM_REQ-1:0] o_onehot,
  output logic [PW-1:0]      o_idx,
  output logic               o_found
);

  logic [PW:0]   w_sum;
  logic [PW-1:0] w_k;

  // Scan from the farthest offset down so the closest hit to the pointer wins.
  always_comb begin
    o_onehot = '0;
    o_idx    = '0;
    o_found  = 1'b0;
    w_sum    = '0;
    w_k      = '0;
    for (int off = NUM_REQ - 1; off >= 0; off--) begin
      w_sum = {1'b0, i_ptr} + (PW+1)'(off);
      if (w_sum >= (PW+1)'(NUM_REQ)) w_sum = w_sum - (PW+1)'(NUM_REQ);
      w_k = w_sum[PW-1:0];
      if (i_req[w_k]) begin
        o_onehot      = '0;
        o_onehot[w_k] = 1'b1;
        o_idx         = w_k;
        o_found       = 1'b1;
      end
    end
  end

endmodule

// File: rtl/spi_master_arbiter.sv
// Round-robin sharing of one SPI master driver among NUM_REQ requesters,
// with optional burst hold and a stalled-driver watchdog.
module spi_master_arbiter
  import spi_arb_pkg::*;
#(
  parameter int NUM_REQ        = 2,
  parameter int NUM_DATA_BITS  = 8,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                               sys_clk,
  input  logic                               rst_n,
  input  logic [NUM_REQ-1:0]                 req,
  input  logic [NUM_REQ-1:0]                 req_last,
  input  logic [NUM_REQ*NUM_DATA_BITS-1:0]   tx_data,
  output logic [NUM_REQ-1:0]                 tx_ack,
  output logic [NUM_REQ-1:0]                 rx_valid,
  output logic [NUM_DATA_BITS-1:0]           rx_data,
  output logic [NUM_REQ-1:0]                 grant,
  output logic                               timeout_err,
  output logic                               drv_comm_start,
  output logic [NUM_DATA_BITS-1:0]           drv_mosi_data,
  input  logic                               drv_bus_ready,
  input  logic                               drv_miso_new_data,
  input  logic [NUM_DATA_BITS-1:0]           drv_miso_data,
  output logic [1:0]                         dbg_state
);

  localparam int PW   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int WD_W = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [WD_W-1:0] WD_LAST =
    (TIMEOUT_CYCLES > 1) ? WD_W'(TIMEOUT_CYCLES - 1) : WD_W'(1);

  // Handshake: a requester holds req with its word on tx_data; the word is
  // consumed in the cycle tx_ack pulses, after which the requester presents
  // its next word (and req_last) or drops req.
  arb_state_t                 r_state;
  logic [PW-1:0]              r_ptr;
  logic [PW-1:0]              r_owner;
  logic [NUM_REQ-1:0]         r_grant;
  logic [NUM_REQ-1:0]         r_tx_ack;
  logic [NUM_REQ-1:0]         r_rx_valid;
  logic [NUM_DATA_BITS-1:0]   r_rx_data;
  logic [NUM_DATA_BITS-1:0]   r_mosi;
  logic                       r_comm_start;
  logic                       r_timeout;
  logic                       r_last;
  logic                       r_seen;
  logic [WD_W-1:0]            r_wd;

  logic [NUM_REQ-1:0]         w_sel_onehot;
  logic [PW-1:0]              w_sel_idx;
  logic                       w_sel_found;
  logic [PW-1:0]              w_issue_idx;
  logic [NUM_DATA_BITS-1:0]   w_issue_data;
  logic                       w_issue_last;
  logic                       w_owner_req;
  logic                       w_seen_now;
  logic                       w_wd_expire;
  logic [PW-1:0]              w_next_ptr;

  rr_select #(.NUM_REQ(NUM_REQ), .PW(PW)) u_rr_select (
    .i_req    (req),
    .i_ptr    (r_ptr),
    .o_onehot (w_sel_onehot),
    .o_idx    (w_sel_idx),
    .o_found  (w_sel_found)
  );

  assign w_issue_idx  = (r_state == ST_IDLE) ? w_sel_idx : r_owner;
  assign w_issue_last = req_last[w_issue_idx];
  assign w_owner_req  = req[r_owner];
  assign w_seen_now   = r_seen | drv_miso_new_data;
  assign w_next_ptr   = PW'(rr_next(32'(r_owner), NUM_REQ));
  assign w_wd_expire  = (TIMEOUT_CYCLES > 0) &&
                        ((r_state == ST_WAIT_BUSY) || (r_state == ST_WAIT_DONE)) &&
                        (r_wd >= WD_LAST);

  always_comb begin
    w_issue_data = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (w_issue_idx == PW'(i)) w_issue_data = tx_data[i*NUM_DATA_BITS +: NUM_DATA_BITS];
    end
  end

  always_ff @(posedge sys_clk) begin
    if (!rst_n) begin
      r_state      <= ST_IDLE;
      r_ptr        <= '0;
      r_owner      <= '0;
      r_grant      <= '0;
      r_tx_ack     <= '0;
      r_rx_valid   <= '0;
      r_rx_data    <= '0;
      r_mosi       <= '0;
      r_comm_start <= 1'b0;
      r_timeout    <= 1'b0;
      r_last       <= 1'b0;
      r_seen       <= 1'b0;
      r_wd         <= '0;
    end else begin
      r_comm_start <= 1'b0;
      r_tx_ack     <= '0;
      r_rx_valid   <= '0;
      r_timeout    <= 1'b0;
      if ((r_state == ST_WAIT_BUSY) || (r_state == ST_WAIT_DONE)) r_wd <= r_wd + WD_W'(1);

      if (w_wd_expire) begin
        r_timeout <= 1'b1;
        r_grant   <= '0;
        r_ptr     <= w_next_ptr;
        r_state   <= ST_IDLE;
      end else begin
        case (r_state)
          ST_IDLE: begin
            if (drv_bus_ready && w_sel_found) begin
              r_owner      <= w_sel_idx;
              r_grant      <= w_sel_onehot;
              r_comm_start <= 1'b1;
              r_mosi       <= w_issue_data;
              r_tx_ack     <= w_sel_onehot;
              r_last       <= w_issue_last;
              r_state      <= ST_ISSUE;
            end
          end
          ST_ISSUE: begin
            r_wd    <= WD_W'(1);
            r_seen  <= 1'b0;
            r_state <= ST_WAIT_BUSY;
          end
          ST_WAIT_BUSY: begin
            if (!drv_bus_ready) r_state <= ST_WAIT_DONE;
          end
          ST_WAIT_DONE: begin
            if (drv_miso_new_data) begin
              r_rx_data  <= drv_miso_data;
              r_rx_valid <= r_grant;
              r_seen     <= 1'b1;
            end
            // Data capture above and the ready transition may share a cycle.
            if (drv_bus_ready && w_seen_now) begin
              if (!r_last && w_owner_req) begin
                r_comm_start <= 1'b1;
                r_mosi       <= w_issue_data;
                r_tx_ack     <= r_grant;
                r_last       <= w_issue_last;
                r_state      <= ST_ISSUE;
              end else begin
                r_grant <= '0;
                r_ptr   <= w_next_ptr;
                r_state <= ST_IDLE;
              end
            end
          end
          default: r_state <= ST_IDLE;
        endcase
      end
    end
  end

  assign tx_ack         = r_tx_ack;
  assign rx_valid       = r_rx_valid;
  assign rx_data        = r_rx_data;
  assign grant          = r_grant;
  assign timeout_err    = r_timeout;
  assign drv_comm_start = r_comm_start;
  assign drv_mosi_data  = r_mosi;
  assign dbg_state      = r_state;

endmodule

// File: tb/tb_spi_master_arbiter.sv
// Directed bench for spi_master_arbiter with a behavioural SPI driver model.
module tb_spi_master_arbiter;
  import spi_arb_pkg::*;

  localparam int NR   = 2;
  localparam int W    = 8;
  localparam int TO   = 64;
  localparam int XFER = 4;

  logic              sys_clk = 1'b0;
  logic              rst_n;
  logic [NR-1:0]     req, req_last;
  logic [NR*W-1:0]   tx_data;
  logic [NR-1:0]     tx_ack, rx_valid, grant;
  logic [W-1:0]      rx_data, drv_mosi_data;
  logic              timeout_err, drv_comm_start;
  logic              drv_bus_ready = 1'b1;
  logic              drv_miso_new_data = 1'b0;
  logic [W-1:0]      drv_miso_data = '0;
  logic [1:0]        dbg_state;

  int checks = 0;
  int errors = 0;

  spi_master_arbiter #(.NUM_REQ(NR), .NUM_DATA_BITS(W), .TIMEOUT_CYCLES(TO)) dut (
    .sys_clk(sys_clk), .rst_n(rst_n), .req(req), .req_last(req_last), .tx_data(tx_data),
    .tx_ack(tx_ack), .rx_valid(rx_valid), .rx_data(rx_data), .grant(grant),
    .timeout_err(timeout_err), .drv_comm_start(drv_comm_start), .drv_mosi_data(drv_mosi_data),
    .drv_bus_ready(drv_bus_ready), .drv_miso_new_data(drv_miso_new_data),
    .drv_miso_data(drv_miso_data), .dbg_state(dbg_state)
  );

  // clock / reset
  always #5 sys_clk = ~sys_clk;

  initial begin
    #500000;
    $display("FAIL global_timeout: observed no finish, expected finish");
    $fatal(1, "bench time limit");
  end

  // driver model: busy XFER cycles after comm_start, returns queued words
  logic [W-1:0] resp_q[$];
  logic [W-1:0] m_resp;
  bit           m_busy = 0;
  int           m_cnt = 0;
  bit           model_hang = 0;
  int           model_gap = 0;

  always @(negedge sys_clk) begin
    drv_miso_new_data = 1'b0;
    if (!rst_n) begin
      drv_bus_ready = 1'b1;
      m_busy = 0;
      m_cnt = 0;
    end else if (drv_comm_start && !m_busy) begin
      m_busy = 1;
      m_cnt = XFER;
      drv_bus_ready = 1'b0;
      m_resp = (resp_q.size() > 0) ? resp_q.pop_front() : '0;
    end else if (m_busy && !model_hang) begin
      m_cnt--;
      if (m_cnt == model_gap) begin
        drv_miso_new_data = 1'b1;
        drv_miso_data = m_resp;
      end
      if (m_cnt == 0) begin
        drv_bus_ready = 1'b1;
        m_busy = 0;
      end
    end
  end

  // monitor: event logs sampled 1 time unit after the active edge
  logic [NR+W-1:0] tx_log[$];
  logic [NR+W-1:0] rx_log[$];
  int tx_cyc[$];
  int rx_cyc[$];
  int cyc = 0, cs_total = 0, cs_double = 0, multi_grant = 0, ack_no_cs = 0;
  int to_cnt = 0, to_cyc = 0;
  bit cs_prev = 0;

  always @(posedge sys_clk) begin
    #1;
    cyc++;
    if (tx_ack != '0) begin
      tx_log.push_back({tx_ack, drv_mosi_data});
      tx_cyc.push_back(cyc);
      if (!drv_comm_start) ack_no_cs++;
    end
    if (rx_valid != '0) begin
      rx_log.push_back({rx_valid, rx_data});
      rx_cyc.push_back(cyc);
    end
    if (drv_comm_start) begin
      cs_total++;
      if (cs_prev) cs_double++;
    end
    cs_prev = drv_comm_start;
    if ($countones(grant) > 1) multi_grant++;
    if (timeout_err) begin
      to_cnt++;
      to_cyc = cyc;
    end
  end

  // scoreboard helpers
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic clear_logs();
    tx_log.delete(); rx_log.delete(); tx_cyc.delete(); rx_cyc.delete();
    cs_total = 0; cs_double = 0; multi_grant = 0; ack_no_cs = 0; to_cnt = 0;
  endtask

  task automatic do_reset(input int n);
    @(negedge sys_clk);
    #1 rst_n = 1'b0;
    req = '0;
    req_last = '0;
    repeat (n) @(negedge sys_clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic wait_tx(input int n, input string tag);
    int b = 0;
    while (tx_log.size() < n && b < 300) begin @(negedge sys_clk); b++; end
    check(tag, 32'(tx_log.size() >= n), 32'd1);
  endtask

  task automatic wait_rx(input int n, input string tag);
    int b = 0;
    while (rx_log.size() < n && b < 300) begin @(negedge sys_clk); b++; end
    check(tag, 32'(rx_log.size() >= n), 32'd1);
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_grant"}, 32'(grant), 32'd0);
    check({tag, "_tx_ack"}, 32'(tx_ack), 32'd0);
    check({tag, "_rx_valid"}, 32'(rx_valid), 32'd0);
    check({tag, "_rx_data"}, 32'(rx_data), 32'd0);
    check({tag, "_timeout"}, 32'(timeout_err), 32'd0);
    check({tag, "_comm_start"}, 32'(drv_comm_start), 32'd0);
    check({tag, "_mosi"}, 32'(drv_mosi_data), 32'd0);
    check({tag, "_state"}, 32'(dbg_state), 32'(ST_IDLE));
  endtask

  // directed steps
  initial begin
    rst_n = 1'b0; req = '0; req_last = '0; tx_data = '0;
    repeat (3) @(negedge sys_clk);
    check_idle_outputs("reset");
    #1 rst_n = 1'b1;

    // single word from requester 0
    clear_logs();
    resp_q.push_back(8'h3C);
    tx_data = {8'h77, 8'hA5}; req_last = 2'b01; req = 2'b01;
    wait_tx(1, "t1_wait_tx");
    req = 2'b00;
    wait_rx(1, "t1_wait_rx");
    repeat (3) @(negedge sys_clk);
    check("t1_tx", 32'(tx_log[0]), 32'({2'b01, 8'hA5}));
    check("t1_cs_count", cs_total, 1);
    check("t1_cs_width", cs_double, 0);
    check("t1_ack_with_cs", ack_no_cs, 0);
    check("t1_rx", 32'(rx_log[0]), 32'({2'b01, 8'h3C}));
    check("t1_latency", rx_cyc[0] - tx_cyc[0], 5);
    check("t1_grant_rel", 32'(grant), 32'd0);
    check("t1_mosi_hold", 32'(drv_mosi_data), 32'hA5);

    // both requesting, single words, three rounds
    do_reset(2);
    clear_logs();
    resp_q.push_back(8'h11); resp_q.push_back(8'h22); resp_q.push_back(8'h33);
    tx_data = {8'hB1, 8'hB0}; req_last = 2'b11; req = 2'b11;
    wait_tx(3, "t2_wait_tx");
    req = 2'b00;
    wait_rx(3, "t2_wait_rx");
    repeat (3) @(negedge sys_clk);
    check("t2_tx0", 32'(tx_log[0]), 32'({2'b01, 8'hB0}));
    check("t2_tx1", 32'(tx_log[1]), 32'({2'b10, 8'hB1}));
    check("t2_tx2", 32'(tx_log[2]), 32'({2'b01, 8'hB0}));
    check("t2_gap01", tx_cyc[1] - tx_cyc[0], 6);
    check("t2_gap12", tx_cyc[2] - tx_cyc[1], 6);
    check("t2_rx1", 32'(rx_log[1]), 32'({2'b10, 8'h22}));
    check("t2_rx2", 32'(rx_log[2]), 32'({2'b01, 8'h33}));
    check("t2_onehot", multi_grant, 0);
    check("t2_cs_count", cs_total, 3);

    // burst on requester 1, requester 0 arrives mid-burst
    clear_logs();
    model_gap = 1;
    resp_q.push_back(8'h81); resp_q.push_back(8'h82);
    resp_q.push_back(8'h83); resp_q.push_back(8'h84);
    tx_data = {8'h01, 8'hC0}; req_last = 2'b00; req = 2'b10;
    wait_tx(1, "t3_wait_w1");
    tx_data[15:8] = 8'h02;
    wait_tx(2, "t3_wait_w2");
    tx_data[15:8] = 8'h03; req_last = 2'b11; req = 2'b11;
    wait_tx(3, "t3_wait_w3");
    req = 2'b01;
    wait_tx(4, "t3_wait_r0");
    req = 2'b00;
    wait_rx(4, "t3_wait_rx");
    repeat (3) @(negedge sys_clk);
    check("t3_tx0", 32'(tx_log[0]), 32'({2'b10, 8'h01}));
    check("t3_tx1", 32'(tx_log[1]), 32'({2'b10, 8'h02}));
    check("t3_tx2", 32'(tx_log[2]), 32'({2'b10, 8'h03}));
    check("t3_tx3", 32'(tx_log[3]), 32'({2'b01, 8'hC0}));
    check("t3_burst_gap1", tx_cyc[1] - tx_cyc[0], 5);
    check("t3_burst_gap2", tx_cyc[2] - tx_cyc[1], 5);
    check("t3_release_gap", tx_cyc[3] - tx_cyc[2], 6);
    check("t3_rx_latency", rx_cyc[0] - tx_cyc[0], 4);
    check("t3_rx0", 32'(rx_log[0]), 32'({2'b10, 8'h81}));
    check("t3_rx2", 32'(rx_log[2]), 32'({2'b10, 8'h83}));
    check("t3_rx3", 32'(rx_log[3]), 32'({2'b01, 8'h84}));
    check("t3_onehot", multi_grant, 0);
    model_gap = 0;

    // hung driver and watchdog
    do_reset(2);
    clear_logs();
    model_hang = 1;
    tx_data = {8'h00, 8'hD4}; req_last = 2'b01; req = 2'b01;
    wait_tx(1, "t4_wait_tx");
    req = 2'b00;
    begin
      int b = 0;
      while (to_cnt == 0 && b < 300) begin @(negedge sys_clk); b++; end
      check("t4_wait_timeout", 32'(to_cnt > 0), 32'd1);
    end
    req = 2'b01;
    repeat (20) @(negedge sys_clk);
    req = 2'b00;
    check("t4_to_count", to_cnt, 1);
    check("t4_to_delay", to_cyc - tx_cyc[0], TO);
    check("t4_no_rx", rx_log.size(), 0);
    check("t4_grant", 32'(grant), 32'd0);
    check("t4_cs_blocked", cs_total, 1);
    check("t4_state", 32'(dbg_state), 32'(ST_IDLE));
    model_hang = 0;
    do_reset(2);

    // reset during WAIT_DONE
    clear_logs();
    tx_data = {8'h95, 8'hE5}; req_last = 2'b01; req = 2'b01;
    wait_tx(1, "t5_wait_tx");
    req = 2'b00;
    repeat (2) @(negedge sys_clk);
    check("t5_in_wait_done", 32'(dbg_state), 32'(ST_WAIT_DONE));
    #1 rst_n = 1'b0;
    @(negedge sys_clk);
    check_idle_outputs("t5_reset");
    #1 rst_n = 1'b1;
    repeat (8) @(negedge sys_clk);
    check("t5_no_rx", rx_log.size(), 0);
    check("t5_no_reissue", tx_log.size(), 1);
    clear_logs();
    resp_q.push_back(8'h55);
    tx_data = {8'h95, 8'h90}; req_last = 2'b11; req = 2'b11;
    wait_tx(1, "t5_wait_tx2");
    req = 2'b00;
    wait_rx(1, "t5_wait_rx2");
    check("t5_first_grant", 32'(tx_log[0]), 32'({2'b01, 8'h90}));
    check("t5_rx", 32'(rx_log[0]), 32'({2'b01, 8'h55}));

    // burst abort: last=0 but req dropped after first word
    repeat (3) @(negedge sys_clk);
    clear_logs();
    resp_q.push_back(8'h96);
    tx_data = {8'hA9, 8'h6A}; req_last = 2'b00; req = 2'b01;
    wait_tx(1, "t6_wait_tx");
    req = 2'b00;
    wait_rx(1, "t6_wait_rx");
    repeat (10) @(negedge sys_clk);
    check("t6_tx_count", tx_log.size(), 1);
    check("t6_rx_count", rx_log.size(), 1);
    check("t6_rx", 32'(rx_log[0]), 32'({2'b01, 8'h96}));
    check("t6_grant", 32'(grant), 32'd0);
    check("t6_state", 32'(dbg_state), 32'(ST_IDLE));
    clear_logs();
    resp_q.push_back(8'h97);
    req_last = 2'b11; req = 2'b11;
    wait_tx(1, "t6_wait_next");
    req = 2'b00;
    wait_rx(1, "t6_wait_next_rx");
    check("t6_ptr_next", 32'(tx_log[0]), 32'({2'b10, 8'hA9}));
    check("t6_onehot", multi_grant, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/spi_master_arbiter.md
Name: spi_master_arbiter

Overview:
Shares one SpiMasterDriver instance between NUM_REQ requesters using round-robin arbitration. Optionally holds the grant across multi-word bursts. The block drives the driver's comm_start and mosi_data and waits on bus_ready and miso_new_data. Received words are routed back to the granted requester, and a stalled driver is detected by a watchdog. It sits between protocol-level bus logic (interceptors, injectors) and the SPI physical layer.

Parameters:
NUM_REQ, 2, number of requesters (2..8)
NUM_DATA_BITS, 8, word width; must match the driver
TIMEOUT_CYCLES, 1024, max sys_clk cycles from comm_start to bus_ready re-asserting; 0 disables the watchdog

Ports:
sys_clk  in  1  system clock
rst_n  in  1  synchronous, active-low reset
req  in  NUM_REQ  level request per requester; held while words remain
req_last  in  NUM_REQ  per requester: the currently offered word is the final word of its burst
tx_data  in  NUM_REQ*NUM_DATA_BITS  packed words; requester i occupies bits [i*W +: W]
tx_ack  out  NUM_REQ  1-cycle pulse: the word from requester i has been issued
rx_valid  out  NUM_REQ  1-cycle pulse: rx_data holds requester i's received word
rx_data  out  NUM_DATA_BITS  last received word, shared by all requesters
grant  out  NUM_REQ  one-hot current owner, or all zero
timeout_err  out  1  1-cycle pulse on watchdog expiry
drv_comm_start  out  1  to driver comm_start
drv_mosi_data  out  NUM_DATA_BITS  to driver mosi_data
drv_bus_ready  in  1  from driver bus_ready
drv_miso_new_data  in  1  from driver miso_new_data
drv_miso_data  in  NUM_DATA_BITS  from driver miso_data

Behaviour:
- Reset (rst_n=0 at a sys_clk edge): all outputs 0; state IDLE; round-robin pointer = 0; watchdog cleared. Top level drives the driver's rst with ~rst_n.
- Reset mid-transfer: grant dropped, no tx_ack/rx_valid emitted, any pending word discarded.
- All outputs are registered. drv_mosi_data holds its value until the next ISSUE.
- State IDLE:
  - Condition to leave: drv_bus_ready=1 and req!=0.
  - Owner = first set req bit scanning upward from the pointer, wrapping modulo NUM_REQ.
  - Set grant; go to ISSUE.
- State ISSUE (1 cycle):
  - drv_comm_start=1; drv_mosi_data=tx_data of the owner; tx_ack[owner]=1.
  - Latch req_last[owner] into last_q; load the watchdog; go to WAIT_BUSY.
- State WAIT_BUSY:
  - Wait for drv_bus_ready=0 (expected one cycle after comm_start); then go to WAIT_DONE.
- State WAIT_DONE:
  - On drv_miso_new_data=1: rx_data<=drv_miso_data; rx_valid[owner]=1 on the following cycle.
  - On drv_bus_ready=1, and only after new_data has been seen:
    - If last_q=0 and req[owner]=1: go to ISSUE with the same owner (burst continues).
    - Otherwise: grant<=0, pointer<=(owner+1) mod NUM_REQ, go to IDLE.
- Simultaneous events:
  - new_data and bus_ready in the same cycle: capture the data first, then apply the bus_ready transition in that same cycle.
  - Requests from non-owners during a burst are ignored until release.
- Burst abort: if req[owner] drops between words, release occurs at the end of the current word; there is never a partial word.
- Watchdog (TIMEOUT_CYCLES>0):
  - Counts every cycle in WAIT_BUSY/WAIT_DONE.
  - On reaching TIMEOUT_CYCLES: timeout_err=1 for one cycle, no rx_valid, grant<=0, pointer advanced, go to IDLE.
  - IDLE still blocks on drv_bus_ready, so a hung driver blocks further grants.
- tx_data of a non-owner is never sampled.
- Widths:
  - pointer: $clog2(NUM_REQ) bits, wraps to 0 at NUM_REQ.
  - watchdog: $clog2(TIMEOUT_CYCLES+1) bits.

Decomposition:
- Shared package spi_arb_pkg: state encodings (IDLE, ISSUE, WAIT_BUSY, WAIT_DONE) and a function computing the next round-robin index.
- One natural sub-module, rr_select: combinational priority search from the pointer, outputs one-hot plus index. This keeps the FSM readable and lets the selector be unit-tested alone.
- The watchdog stays inline.

Test Plan:
1. After reset, req=01, tx_data[0]=0xA5, req_last=01; driver model returns 0x3C.
   Expect: drv_comm_start high exactly 1 cycle with drv_mosi_data=0xA5; tx_ack=01; rx_valid=01 with rx_data=0x3C; grant returns to 00.
2. req=11 held, both last=1, three rounds.
   Expect: owner order 0,1,0; each pair of tx_ack pulses separated by a full driver transfer; never two grant bits set.
3. Burst on requester 1 of words 0x01,0x02,0x03, last asserted on 0x03; req[0] raised during word 0x02.
   Expect: three consecutive issues to requester 1 in order; requester 0 granted only after the 0x03 transfer completes.
4. TIMEOUT_CYCLES=64; driver model holds bus_ready low forever after comm_start.
   Expect: timeout_err pulses once, 64 cycles after ISSUE; grant=00; no rx_valid; no further comm_start while bus_ready=0.
5. rst_n pulled low during WAIT_DONE of a requester 0 word.
   Expect: next cycle all outputs 0, no rx_valid; first grant after release goes to requester 0 (pointer=0).
6. Requester 0 with last=0 drops req after word 1.
   Expect: exactly one tx_ack and one rx_valid; grant released; pointer=1.
